// File: rtl/cgra_tile_cfg_mem.sv
// -----------------------------------------------------------------------------
// cgra_tile_cfg_mem
//
// Purpose:
//   Tile-side configuration store for one CGRA tile. Config words arrive over
//   the CSR-to-tile write port and are stored per context. When a run is
//   started, the stored contexts are replayed to the tile datapath, one
//   context per cycle, wrapping after the sampled context length.
//
//   Config word layout (CfgWidth = 49):
//     [48:43] ctrl, [42] predicate, [41:30] fu_in, [29:6] outport,
//     [5:0] predicate_in
//
// Optional feature (macro CGRA_CFG_PARITY_EN):
//   Each stored entry carries an even-parity bit computed at write time. On
//   replay the parity of the emitted word is re-checked; a mismatch raises
//   parity_err_o, which is sticky until the next accepted run start or reset.
//   Without the macro no parity is stored and parity_err_o does not exist.
//
// Ports:
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   cfg_addr_i      context index to write
//   cfg_data_i      config word to write
//   cfg_wr_en_i     write enable for a fired beat (0 = consume without effect)
//   cfg_wr_valid_i  write beat valid
//   cfg_ready_o     tile accepts write beats (only while idle)
//   run_start_i     pulse: begin replay from context 0
//   run_stop_i      pulse: end replay (wins over a simultaneous start)
//   ctx_len_i       number of contexts to replay, sampled at start;
//                   0 or > KernelSize means KernelSize
//   cfg_o           current context config word
//   cfg_valid_o     cfg_o carries a context this cycle
//   ctx_idx_o       index of the context on cfg_o
//   busy_o          replay in progress
//   loaded_o        every context written at least once since reset
//   parity_err_o    (CGRA_CFG_PARITY_EN only) sticky replay parity error
// -----------------------------------------------------------------------------
module cgra_tile_cfg_mem #(
    parameter int KernelSize = 4,
    parameter int CfgWidth   = 49,
    localparam int AW        = $clog2(KernelSize)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [AW-1:0]       cfg_addr_i,
    input  logic [CfgWidth-1:0] cfg_data_i,
    input  logic                cfg_wr_en_i,
    input  logic                cfg_wr_valid_i,
    output logic                cfg_ready_o,
    input  logic                run_start_i,
    input  logic                run_stop_i,
    input  logic [AW:0]         ctx_len_i,
    output logic [CfgWidth-1:0] cfg_o,
    output logic                cfg_valid_o,
    output logic [AW-1:0]       ctx_idx_o,
    output logic                busy_o,
`ifdef CGRA_CFG_PARITY_EN
    output logic                parity_err_o,
`endif
    output logic                loaded_o
);

    // Full-length replay value and small constants at their exact widths.
    localparam logic [AW:0]   LenMax  = (AW+1)'(KernelSize);
    localparam logic [AW:0]   LenOne  = (AW+1)'(1);
    localparam logic [AW:0]   LenZero = (AW+1)'(0);
    localparam logic [AW-1:0] CtrOne  = AW'(1);
    localparam logic [AW-1:0] CtrZero = AW'(0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Even parity of a config word.
    function automatic logic parity_f(input logic [CfgWidth-1:0] word);
        return ^word;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [CfgWidth-1:0] mem_q [KernelSize];
    logic [CfgWidth-1:0] mem_d [KernelSize];
    logic [KernelSize-1:0] mask_q, mask_d;
    logic                loaded_q, loaded_d;
    logic [AW-1:0]       ctr_q, ctr_d;
    logic [AW:0]         len_q, len_d;
    logic [CfgWidth-1:0] cfg_q, cfg_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic [AW-1:0]       ctx_idx_q, ctx_idx_d;

`ifdef CGRA_CFG_PARITY_EN
    logic                par_q [KernelSize];
    logic                par_d [KernelSize];
    logic                par_err_q, par_err_d;
`endif

    logic                wr_fire_s;
    logic                start_ok_s;
    logic [AW:0]         len_sel_s;
    logic                ctr_last_s;

    // -------------------------------------------------------------------------
    // Handshake and run-control decode
    // -------------------------------------------------------------------------
    assign cfg_ready_o = (state_q == ST_IDLE);
    assign wr_fire_s   = cfg_wr_valid_i && cfg_ready_o;
    // A stop in the same cycle as a start cancels the start.
    assign start_ok_s  = run_start_i && !run_stop_i;
    // Zero and oversize lengths both mean "replay the whole kernel".
    assign len_sel_s   = ((ctx_len_i == LenZero) || (ctx_len_i > LenMax)) ? LenMax : ctx_len_i;
    assign ctr_last_s  = ({1'b0, ctr_q} == (len_q - LenOne));

    // Config memory, loaded mask and parity storage next-state.
    always_comb begin
        mem_d  = mem_q;
        mask_d = mask_q;
`ifdef CGRA_CFG_PARITY_EN
        par_d  = par_q;
`endif
        if (wr_fire_s && cfg_wr_en_i) begin
            mem_d[cfg_addr_i]  = cfg_data_i;
            mask_d[cfg_addr_i] = 1'b1;
`ifdef CGRA_CFG_PARITY_EN
            par_d[cfg_addr_i]  = parity_f(cfg_data_i);
`endif
        end else begin
            mem_d  = mem_q;
            mask_d = mask_q;
`ifdef CGRA_CFG_PARITY_EN
            par_d  = par_q;
`endif
        end
        // Taken from the post-write mask so loaded_o rises right after the
        // edge that completes the set.
        loaded_d = &mask_d;
    end

    // Replay FSM next-state and datapath outputs.
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        len_d       = len_q;
        cfg_d       = {CfgWidth{1'b0}};
        cfg_valid_d = 1'b0;
        ctx_idx_d   = CtrZero;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                    len_d   = len_sel_s;
                    ctr_d   = CtrZero;
                end else begin
                    state_d = ST_IDLE;
                    len_d   = len_q;
                    ctr_d   = ctr_q;
                end
            end
            ST_RUN: begin
                if (run_stop_i) begin
                    // The stop cycle emits nothing and parks the counter.
                    state_d = ST_IDLE;
                    ctr_d   = CtrZero;
                end else begin
                    state_d     = ST_RUN;
                    cfg_d       = mem_q[ctr_q];
                    cfg_valid_d = 1'b1;
                    ctx_idx_d   = ctr_q;
                    ctr_d       = ctr_last_s ? CtrZero : (ctr_q + CtrOne);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctr_d   = CtrZero;
                len_d   = LenZero;
            end
        endcase
    end

`ifdef CGRA_CFG_PARITY_EN
    // Sticky parity error: cleared by an accepted start, set by any emitted
    // context whose recomputed parity disagrees with the stored bit.
    always_comb begin
        par_err_d = par_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    par_err_d = 1'b0;
                end else begin
                    par_err_d = par_err_q;
                end
            end
            ST_RUN: begin
                if (run_stop_i) begin
                    par_err_d = par_err_q;
                end else begin
                    par_err_d = par_err_q | (par_q[ctr_q] != parity_f(mem_q[ctr_q]));
                end
            end
            default: begin
                par_err_d = par_err_q;
            end
        endcase
    end
`endif

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mask_q      <= {KernelSize{1'b0}};
            loaded_q    <= 1'b0;
            ctr_q       <= CtrZero;
            len_q       <= LenZero;
            cfg_q       <= {CfgWidth{1'b0}};
            cfg_valid_q <= 1'b0;
            ctx_idx_q   <= CtrZero;
            for (int i = 0; i < KernelSize; i++) begin
                mem_q[i] <= {CfgWidth{1'b0}};
`ifdef CGRA_CFG_PARITY_EN
                par_q[i] <= 1'b0;
`endif
            end
`ifdef CGRA_CFG_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            loaded_q    <= loaded_d;
            ctr_q       <= ctr_d;
            len_q       <= len_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            ctx_idx_q   <= ctx_idx_d;
            for (int i = 0; i < KernelSize; i++) begin
                mem_q[i] <= mem_d[i];
`ifdef CGRA_CFG_PARITY_EN
                par_q[i] <= par_d[i];
`endif
            end
`ifdef CGRA_CFG_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cfg_o       = cfg_q;
    assign cfg_valid_o = cfg_valid_q;
    assign ctx_idx_o   = ctx_idx_q;
    assign busy_o      = (state_q == ST_RUN);
    assign loaded_o    = loaded_q;
`ifdef CGRA_CFG_PARITY_EN
    assign parity_err_o = par_err_q;
`endif

endmodule
